// File: rtl/tof_cycle_executor.sv
// tof_cycle_executor
//
// Runs one ToF capture cycle per accepted start request. The sequence is
// settle, then integrate with modulation enabled, then a full PPI frame
// readout, then a single DONE cycle that pulses cycle_finished_o. The
// modulation phase is latched when the start is accepted and held until
// the next acceptance.
//
// Ports:
//   clk_i              clock; all logic on the rising edge
//   rst_i              synchronous, active-high reset; aborts any cycle
//   start_cycle_i      start request, level-sampled only while idle
//   modsel_phase_i     modulation phase, captured with an accepted start
//   busy_o             high from the cycle after acceptance through DONE
//   modsel_phase_o     phase latched at the last acceptance
//   mod_en_o           modulation / integration enable
//   ppi_frame_valid_o  high for the whole readout, blanks included
//   ppi_line_valid_o   high while pix_x_o addresses an active pixel
//   pix_x_o            column counter, 0 outside readout
//   line_y_o           line counter, 0 outside readout
//   cycle_finished_o   single-cycle pulse in the DONE cycle
//
// Every output is a flop. Each state transition loads the output values
// that belong to the state being entered, so outputs line up exactly with
// the state register without any combinational decode on the outputs.

module tof_cycle_executor #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned INTEG_CYCLES  = 1000,
  parameter int unsigned H_PIXELS      = 160,
  parameter int unsigned H_BLANK       = 16,
  parameter int unsigned V_LINES       = 120,
  localparam int unsigned HTotal = H_PIXELS + H_BLANK,
  localparam int unsigned PixW   = (HTotal > 1) ? $clog2(HTotal) : 1,
  localparam int unsigned LineW  = (V_LINES > 1) ? $clog2(V_LINES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_cycle_i,
  input  logic [7:0]       modsel_phase_i,
  output logic             busy_o,
  output logic [7:0]       modsel_phase_o,
  output logic             mod_en_o,
  output logic             ppi_frame_valid_o,
  output logic             ppi_line_valid_o,
  output logic [PixW-1:0]  pix_x_o,
  output logic [LineW-1:0] line_y_o,
  output logic             cycle_finished_o
);

  // The shared phase counter only ever reaches max(S, I) - 1, so this width
  // never wraps inside a state.
  localparam int unsigned CntMax = (SETTLE_CYCLES > INTEG_CYCLES) ? SETTLE_CYCLES
                                                                  : INTEG_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  IntegLast  = CntW'(INTEG_CYCLES - 1);
  localparam logic [PixW-1:0]  PixLast    = PixW'(HTotal - 1);
  localparam logic [PixW-1:0]  PixActive  = PixW'(H_PIXELS);
  localparam logic [LineW-1:0] LineLast   = LineW'(V_LINES - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSettle    = 3'd1,
    StIntegrate = 3'd2,
    StReadout   = 3'd3,
    StDone      = 3'd4
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic [7:0]       phase_q;
  logic             mod_en_q;
  logic             frame_valid_q;
  logic             line_valid_q;
  logic [PixW-1:0]  pix_q;
  logic [LineW-1:0] line_q;
  logic             finished_q;

  // Next column within a line; only used when pix_q is below PixLast, so the
  // increment cannot overflow.
  logic [PixW-1:0]  pix_inc;
  assign pix_inc = pix_q + PixW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      phase_q       <= 8'h00;
      mod_en_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      line_valid_q  <= 1'b0;
      pix_q         <= '0;
      line_q        <= '0;
      finished_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_cycle_i) begin
            phase_q <= modsel_phase_i;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StSettle;
          end
        end

        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q    <= '0;
            mod_en_q <= 1'b1;
            state_q  <= StIntegrate;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StIntegrate: begin
          if (cnt_q == IntegLast) begin
            cnt_q         <= '0;
            mod_en_q      <= 1'b0;
            frame_valid_q <= 1'b1;
            // Column 0 is always an active pixel.
            line_valid_q  <= 1'b1;
            pix_q         <= '0;
            line_q        <= '0;
            state_q       <= StReadout;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StReadout: begin
          if (pix_q == PixLast) begin
            if (line_q == LineLast) begin
              // Last blank column of the last line: frame complete.
              frame_valid_q <= 1'b0;
              line_valid_q  <= 1'b0;
              pix_q         <= '0;
              line_q        <= '0;
              finished_q    <= 1'b1;
              state_q       <= StDone;
            end else begin
              pix_q        <= '0;
              line_q       <= line_q + LineW'(1);
              line_valid_q <= 1'b1;
            end
          end else begin
            pix_q        <= pix_inc;
            line_valid_q <= (pix_inc < PixActive);
          end
        end

        StDone: begin
          // Starts seen here are dropped; a new one is only taken in idle.
          finished_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end

        default: begin
          // Illegal encoding: park in idle with quiet outputs, phase retained.
          state_q       <= StIdle;
          cnt_q         <= '0;
          busy_q        <= 1'b0;
          mod_en_q      <= 1'b0;
          frame_valid_q <= 1'b0;
          line_valid_q  <= 1'b0;
          pix_q         <= '0;
          line_q        <= '0;
          finished_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign modsel_phase_o    = phase_q;
  assign mod_en_o          = mod_en_q;
  assign ppi_frame_valid_o = frame_valid_q;
  assign ppi_line_valid_o  = line_valid_q;
  assign pix_x_o           = pix_q;
  assign line_y_o          = line_q;
  assign cycle_finished_o  = finished_q;

endmodule

// File: tb/tb_tof_cycle_executor.sv
// Directed bench for tof_cycle_executor with S=2, I=5, H=4+2, V=3 (F=18).
// Observation j is the output value seen between edges k+j-1 and k+j, where
// edge k accepted the start; stimulus driven in iteration j is sampled at
// edge k+j.

module tb_tof_cycle_executor;

  localparam int S    = 2;
  localparam int I    = 5;
  localparam int HP   = 4;
  localparam int HB   = 2;
  localparam int V    = 3;
  localparam int HT   = HP + HB;
  localparam int FR   = V * HT;
  localparam int JFin = S + I + FR + 1;  // 26

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] modsel;
  logic       busy_o;
  logic [7:0] modsel_phase_o;
  logic       mod_en_o;
  logic       fv_o;
  logic       lv_o;
  logic [2:0] pix_x_o;
  logic [1:0] line_y_o;
  logic       fin_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tof_cycle_executor #(
    .SETTLE_CYCLES(S),
    .INTEG_CYCLES (I),
    .H_PIXELS     (HP),
    .H_BLANK      (HB),
    .V_LINES      (V)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_cycle_i    (start),
    .modsel_phase_i   (modsel),
    .busy_o           (busy_o),
    .modsel_phase_o   (modsel_phase_o),
    .mod_en_o         (mod_en_o),
    .ppi_frame_valid_o(fv_o),
    .ppi_line_valid_o (lv_o),
    .pix_x_o          (pix_x_o),
    .line_y_o         (line_y_o),
    .cycle_finished_o (fin_o)
  );

  // Expected {busy, mod_en, fv, lv, fin, pix_x, line_y, phase} at observation j.
  function automatic logic [17:0] exp_vec(int j, logic [7:0] ph);
    logic       b, me, fv, lv, fin;
    logic [2:0] px;
    logic [1:0] ly;
    int         r;
    b   = (j >= 1) && (j <= JFin);
    me  = (j >= S + 1) && (j <= S + I);
    fv  = (j >= S + I + 1) && (j <= S + I + FR);
    fin = (j == JFin);
    px  = 3'd0;
    ly  = 2'd0;
    lv  = 1'b0;
    if (fv) begin
      r  = j - (S + I + 1);
      px = 3'(r % HT);
      ly = 2'(r / HT);
      lv = (r % HT) < HP;
    end
    return {b, me, fv, lv, fin, px, ly, ph};
  endfunction

  function automatic logic [17:0] obs();
    return {busy_o, mod_en_o, fv_o, lv_o, fin_o, pix_x_o, line_y_o, modsel_phase_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start  = 1'b0;
    modsel = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b1;
    modsel = 8'hA5;
    tick();
    checks++;
    if (obs() !== 18'h0) begin
      errors++;
      $display("FAIL reset_hold got %h expected %h", obs(), 18'h0);
    end
    start = 1'b0;
    rst   = 1'b0;
    tick();
    tick();
    checks++;
    if (obs() !== 18'h0) begin
      errors++;
      $display("FAIL reset_idle got %h expected %h", obs(), 18'h0);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    modsel = 8'h5A;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      checks++;
      if (obs() !== exp_vec(j, 8'h5A)) begin
        errors++;
        $display("FAIL nominal j=%0d got %h expected %h", j, obs(), exp_vec(j, 8'h5A));
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    int nfin;
    nfin = 0;
    do_reset();
    modsel = 8'h5A;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    modsel = 8'h33;
    for (int j = 1; j <= 32; j++) begin
      checks++;
      if (obs() !== exp_vec(j, 8'h5A)) begin
        errors++;
        $display("FAIL ignore_busy j=%0d got %h expected %h", j, obs(), exp_vec(j, 8'h5A));
      end
      if (fin_o) nfin++;
      start = (j == 4) || (j == 20);
      tick();
    end
    start = 1'b0;
    checks++;
    if (nfin !== 1) begin
      errors++;
      $display("FAIL ignore_busy_fin_count got %0d expected %0d", nfin, 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    do_reset();
    modsel = 8'h5A;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      e = (j <= 28) ? exp_vec(j, 8'h5A) : exp_vec(j - 28, 8'h40);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL back_to_back j=%0d got %h expected %h", j, obs(), e);
      end
      start  = (j == 26) || (j == 28);
      modsel = (j == 26) ? 8'h77 : 8'h40;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    do_reset();
    modsel = 8'h5A;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (j <= 5)       e = exp_vec(j, 8'h5A);
      else if (j <= 10) e = 18'h0;
      else              e = exp_vec(j - 10, 8'h5A);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_mid j=%0d got %h expected %h", j, obs(), e);
      end
      rst   = (j == 5);
      start = (j == 10);
      tick();
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_held_start();
    logic [17:0] e;
    do_reset();
    modsel = 8'h11;
    start  = 1'b1;
    tick();
    for (int j = 1; j <= 53; j++) begin
      e = (j <= 27) ? exp_vec(j, 8'h11) : exp_vec(j - 27, 8'h11);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL held_start j=%0d got %h expected %h", j, obs(), e);
      end
      if (j == 53) start = 1'b0;
      tick();
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL held_start_release busy got %b expected %b", busy_o, 1'b0);
    end
  endtask

  task automatic test_four_phase();
    logic [7:0] ph;
    logic       got_fin;
    int         nfin;
    nfin = 0;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      ph      = 8'(p * 64);
      modsel  = ph;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      modsel  = ~ph;
      got_fin = 1'b0;
      for (int n = 1; n <= 40 && !got_fin; n++) begin
        checks++;
        if (modsel_phase_o !== ph) begin
          errors++;
          $display("FAIL four_phase_phase p=%0d n=%0d got %h expected %h",
                   p, n, modsel_phase_o, ph);
        end
        if (fin_o) begin
          got_fin = 1'b1;
          nfin++;
          checks++;
          if (n !== JFin) begin
            errors++;
            $display("FAIL four_phase_fin_time p=%0d got %0d expected %0d", p, n, JFin);
          end
        end
        tick();
      end
      checks++;
      if (got_fin !== 1'b1) begin
        errors++;
        $display("FAIL four_phase_timeout p=%0d got %b expected %b", p, got_fin, 1'b1);
      end
    end
    checks++;
    if (nfin !== 4) begin
      errors++;
      $display("FAIL four_phase_fin_count got %0d expected %0d", nfin, 4);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    modsel = 8'h00;
    test_reset();
    test_nominal();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_held_start();
    test_four_phase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tof_cycle_executor.md
Name: tof_cycle_executor

Overview:
Executes one ToF capture cycle at a time for the multicycle sequencer. It accepts a single-cycle start request and latches the requested modulation phase. It then runs settle, integration and pixel readout, and returns a single-cycle cycle-finished pulse. It sits between the multicycle sequencing logic and the sensor modulation / PPI readout path, and drives the frame-valid that the sequencer waits on.

Parameters:
SETTLE_CYCLES  8     clocks between start acceptance and modulation enable; must be >=1
INTEG_CYCLES   1000  clocks with mod_en_o high; must be >=1
H_PIXELS       160   active pixels per line; must be >=1
H_BLANK        16    blank clocks after each line's active pixels; must be >=1
V_LINES        120   lines per frame; must be >=1

Ports:
clk_i              input   1     single clock; all logic on rising edge
rst_i              input   1     synchronous, active-high reset
start_cycle_i      input   1     cycle start request; sampled only in IDLE
modsel_phase_i     input   8     modulation phase for the cycle; sampled with an accepted start
busy_o             output  1     high from the cycle after acceptance through the DONE cycle
modsel_phase_o     output  8     phase latched at acceptance; held until the next acceptance
mod_en_o           output  1     modulation/integration enable
ppi_frame_valid_o  output  1     high for the entire readout (active pixels and blanks)
ppi_line_valid_o   output  1     high during the active pixels of each line
pix_x_o            output  ceil(log2(H_PIXELS+H_BLANK))  column counter; 0 outside READOUT
line_y_o           output  ceil(log2(V_LINES))           line counter; 0 outside READOUT
cycle_finished_o   output  1     single-cycle pulse at the end of the cycle

Behaviour:
- All outputs are registered. Reset value of every output is 0, including modsel_phase_o.
- Reset takes effect at the next edge from any state. It aborts the cycle in progress and does not emit cycle_finished_o.
- FSM states: IDLE, SETTLE, INTEGRATE, READOUT, DONE. The FSM enters IDLE on reset. Unused encodings return to IDLE.
- IDLE:
  - start_cycle_i=1 at edge k: modsel_phase_o <= modsel_phase_i; busy_o <= 1; state becomes SETTLE; counter cleared.
  - The start is level-sampled. If start_cycle_i is held high, a new cycle starts on every IDLE visit.
- SETTLE: lasts exactly SETTLE_CYCLES clocks (cycles k+1 .. k+S).
- INTEGRATE: mod_en_o=1 for exactly INTEG_CYCLES clocks (k+S+1 .. k+S+I), then READOUT.
- READOUT:
  - Frame length F = V_LINES*(H_PIXELS+H_BLANK) clocks; ppi_frame_valid_o=1 for cycles k+S+I+1 .. k+S+I+F.
  - pix_x_o counts 0 .. H_PIXELS+H_BLANK-1 and wraps to 0.
  - line_y_o increments on each pix_x_o wrap; after the last column of line V_LINES-1 the state becomes DONE.
  - ppi_line_valid_o=1 exactly when pix_x_o < H_PIXELS.
- DONE:
  - Lasts one cycle (k+S+I+F+1): cycle_finished_o=1, busy_o still 1, frame_valid/line_valid 0.
  - State becomes IDLE; busy_o=0 from k+S+I+F+2.
- Start requests while not in IDLE, including the DONE cycle, are ignored and are not queued.
- modsel_phase_i changes while busy_o=1 have no effect on modsel_phase_o.
- Counters use width sufficient for max(SETTLE_CYCLES, INTEG_CYCLES) with no wrap inside a state.
- Outputs are fully deterministic from start acceptance. No dependency on sequencer inputs other than start_cycle_i and modsel_phase_i.

Test Plan:
All scenarios use SETTLE=2, INTEG=5, H_PIXELS=4, H_BLANK=2, V_LINES=3 (F=18).
- Nominal: modsel 0x5A, start pulse sampled at edge 10 -> busy_o 1 from 11; modsel_phase_o=0x5A from 11; mod_en_o 1 on 13..17 only; frame_valid 1 on 18..35; line_valid pattern 1111_00 three times; pix_x 0..5, line_y 0..2; cycle_finished_o 1 on 36 only; busy_o 0 from 37.
- Start pulses at 14 and 30 with modsel_phase_i=0x33 during busy -> ignored; single finished pulse at 36; modsel_phase_o stays 0x5A.
- Back-to-back: a second start at 38 with 0x40 -> accepted; modsel_phase_o=0x40 from 39; finished at 64. A start at the DONE cycle 36 alone -> ignored.
- rst_i=1 at edge 15 (mid INTEGRATE) -> from 16 all outputs 0 and no finished pulse; a new start at 20 -> nominal timing relative to 20.
- start_cycle_i held high from 10 -> cycles accepted at 10 and 37 (first IDLE cycle); 2 finished pulses by edge 63.
- Four-phase sequencer model: phases 0x00/0x40/0x80/0xC0 -> 4 frames, 4 finished pulses; each frame's modsel_phase_o matches its phase.
